// File: rtl/cim_spike_aer_encoder_pkg.sv
// Shared types and helpers for the CIM spike AER encoder (optional build macro:
// CIM_AER_NULL_EVENT_EN, handled in the top).
package cim_aer_pkg;

  localparam int unsigned NEURONS_DEFAULT  = 16;
  localparam int unsigned TS_WIDTH_DEFAULT = 8;
  localparam int unsigned ADDR_WIDTH       = $clog2(NEURONS_DEFAULT);
  // Helpers operate on a zero-extended vector so any NEURONS up to this fits.
  localparam int unsigned NEURONS_MAX      = 256;

  typedef enum logic {
    IDLE,
    SEND
  } aer_state_e;

  typedef struct packed {
    logic [TS_WIDTH_DEFAULT-1:0] ts;
    logic [NEURONS_DEFAULT-1:0]  vec;
  } aer_entry_t;

  function automatic int unsigned lowest_set_index(input logic [NEURONS_MAX-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = NEURONS_MAX; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

  function automatic logic onehot_check(input logic [NEURONS_MAX-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/cim_spike_aer_encoder_fifo.sv
// Synchronous FIFO of spike entries; a freshly written head becomes readable one
// cycle after its write. Push and pop may coincide, including when full.
module cim_aer_fifo
  import cim_aer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = aer_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          head_new_q, head_new_d;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // Pushed entry lands at the head: hide it from the reader for one cycle.
    head_new_d = push && ((count_q - CW'(pop)) == '0);
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_new_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_new_q <= head_new_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0) || head_new_q;
  assign count = count_q;

endmodule

// File: rtl/cim_spike_aer_encoder.sv
// Captures timestep-tagged neuron vectors into a FIFO and serializes set bits as
// AER events. Optional macro CIM_AER_NULL_EVENT_EN: zero vectors emit one EV_NULL marker.
module cim_spike_aer_encoder
  import cim_aer_pkg::*;
#(
  parameter int unsigned NEURONS    = NEURONS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_WIDTH   = TS_WIDTH_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ,
  input  logic [NEURONS-1:0]         NEURON_OUT,
  input  logic                       TS_CLR,
  output logic                       BUSY,
  output logic                       EV_VALID,
  input  logic                       EV_READY,
  output logic [$clog2(NEURONS)-1:0] EV_ADDR,
  output logic [TS_WIDTH-1:0]        EV_TS,
  output logic                       EV_LAST,
  output logic                       OVF,
  input  logic                       OVF_CLR
`ifdef CIM_AER_NULL_EVENT_EN
  ,output logic                      EV_NULL
`endif
);

  localparam int unsigned ADDR_W = $clog2(NEURONS);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [NEURONS-1:0]  vec;
  } entry_t;

  aer_state_e           state_q, state_d;
  logic [NEURONS-1:0]   work_q, work_d;
  logic [TS_WIDTH-1:0]  ts_r_q, ts_r_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  logic                 push_req, push, pop, drop;
  entry_t               push_entry, head;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count, cnt_post;
  logic [NEURONS_MAX-1:0] work_ext;
  logic                 ev_last;

  // Timestep counter and capture of the incoming vector.
  always_comb begin
    ts_d = ts_q;
    if (TS_CLR) begin
      ts_d = REQ ? TS_WIDTH'(1) : '0;
    end else if (REQ) begin
      ts_d = ts_q + 1'b1;
    end
    push_entry.ts  = TS_CLR ? '0 : ts_q;
    push_entry.vec = NEURON_OUT;
`ifdef CIM_AER_NULL_EVENT_EN
    push_req = REQ;
`else
    push_req = REQ && (NEURON_OUT != '0);
`endif
  end

  always_comb begin
    push     = push_req && (!fifo_full || pop);
    drop     = push_req && fifo_full && !pop;
    cnt_post = fifo_count + CW'(push) - CW'(pop);
    busy_d   = (cnt_post >= CW'(FIFO_DEPTH - 1));
    ovf_d    = OVF_CLR ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    ts_r_d   = ts_r_q;
    pop      = 1'b0;
    EV_VALID = 1'b0;
    EV_ADDR  = '0;
    EV_TS    = '0;
    ev_last  = 1'b0;
    work_ext = '0;
    work_ext[NEURONS-1:0] = work_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          work_d  = head.vec;
          ts_r_d  = head.ts;
          state_d = SEND;
        end
      end
      SEND: begin
        EV_VALID = 1'b1;
        EV_ADDR  = ADDR_W'(lowest_set_index(work_ext));
        EV_TS    = ts_r_q;
`ifdef CIM_AER_NULL_EVENT_EN
        ev_last  = onehot_check(work_ext) || (work_q == '0);
`else
        ev_last  = onehot_check(work_ext);
`endif
        if (EV_READY) begin
          work_d = work_q & (work_q - 1'b1);
          // Chain straight into the next vector so back-to-back vectors have no bubble.
          if (ev_last) begin
            if (!fifo_empty) begin
              pop    = 1'b1;
              work_d = head.vec;
              ts_r_d = head.ts;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      work_q  <= '0;
      ts_r_q  <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      ts_r_q  <= ts_r_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  cim_aer_fifo #(
    .DEPTH(FIFO_DEPTH),
    .T    (entry_t)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (push),
    .pop  (pop),
    .din  (push_entry),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign EV_LAST = ev_last;
  assign BUSY    = busy_q;
  assign OVF     = ovf_q;
`ifdef CIM_AER_NULL_EVENT_EN
  assign EV_NULL = (state_q == SEND) && (work_q == '0);
`endif

endmodule

// File: tb/tb_cim_spike_aer_encoder.sv
// Self-checking bench for cim_spike_aer_encoder (default build, null events off).
module tb_cim_spike_aer_encoder;

  logic        CLK = 1'b0;
  logic        RST, REQ, TS_CLR, EV_READY, OVF_CLR;
  logic [15:0] NEURON_OUT;
  logic        BUSY, EV_VALID, EV_LAST, OVF;
  logic [3:0]  EV_ADDR;
  logic [7:0]  EV_TS;

  always #5 CLK = ~CLK;

  cim_spike_aer_encoder #(
    .NEURONS   (16),
    .FIFO_DEPTH(4),
    .TS_WIDTH  (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .NEURON_OUT(NEURON_OUT),
    .TS_CLR    (TS_CLR),
    .BUSY      (BUSY),
    .EV_VALID  (EV_VALID),
    .EV_READY  (EV_READY),
    .EV_ADDR   (EV_ADDR),
    .EV_TS     (EV_TS),
    .EV_LAST   (EV_LAST),
    .OVF       (OVF),
    .OVF_CLR   (OVF_CLR)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] ts;
    logic       last;
  } ev_t;

  typedef struct {
    logic [15:0] vec;
    int          n_ev;
    logic [3:0]  lo;
    logic [3:0]  hi;
  } vec_t;

  ev_t        sb[$];
  logic [3:0] obs_addr[$];
  logic [7:0] obs_ts[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_ts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    ev_t        e;
    logic       pv, pr, pl;
    logic [3:0] pa;
    logic [7:0] pt;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pt = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", EV_VALID, 1);
          chk("hold_addr", EV_ADDR, pa);
          chk("hold_ts", EV_TS, pt);
          chk("hold_last", EV_LAST, pl);
        end
        if (EV_VALID && EV_READY) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event act addr=%0d ts=%0d exp none @%0t", EV_ADDR, EV_TS, $time);
          end else begin
            e = sb.pop_front();
            chk("ev_addr", EV_ADDR, e.addr);
            chk("ev_ts", EV_TS, e.ts);
            chk("ev_last", EV_LAST, e.last);
          end
          obs_addr.push_back(EV_ADDR);
          obs_ts.push_back(EV_TS);
        end
        pv = EV_VALID; pr = EV_READY; pa = EV_ADDR; pt = EV_TS; pl = EV_LAST;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 1'b0; NEURON_OUT = '0; TS_CLR = 1'b0; OVF_CLR = 1'b0;
    sb.delete();
    m_ts = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // One REQ cycle; expected events are queued unless the vector is expected to drop.
  task automatic do_req(input logic [15:0] v, input logic clr, input logic drop);
    logic [7:0] tag;
    ev_t        e;
    tag = clr ? 8'd0 : m_ts;
    if (v != 16'd0 && !drop) begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) begin
          e.addr = 4'(i);
          e.ts   = tag;
          e.last = ((v >> (i + 1)) == 16'd0);
          sb.push_back(e);
        end
      end
    end
    m_ts = clr ? 8'd1 : m_ts + 8'd1;
    REQ = 1'b1; NEURON_OUT = v; TS_CLR = clr;
    tick();
    REQ = 1'b0; NEURON_OUT = '0; TS_CLR = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !EV_VALID) break;
      tick();
    end
    chk(name, (sb.size() == 0 && !EV_VALID), 1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !EV_VALID; i++) tick();
    chk(name, EV_VALID, 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   base;

    tbl[0] = '{16'h8005, 3, 4'd0, 4'd15};
    tbl[1] = '{16'h0010, 1, 4'd4, 4'd4};
    tbl[2] = '{16'hFFFF, 16, 4'd0, 4'd15};
    tbl[3] = '{16'h8000, 1, 4'd15, 4'd15};
    tbl[4] = '{16'h0101, 2, 4'd0, 4'd8};
    tbl[5] = '{16'h0000, 0, 4'd0, 4'd0};

    EV_READY = 1'b1;
    fork
      monitor();
    join_none

    // Reset state.
    do_reset();
    chk("rst_valid", EV_VALID, 0);
    chk("rst_last", EV_LAST, 0);
    chk("rst_addr", EV_ADDR, 0);
    chk("rst_ts", EV_TS, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVF, 0);

    // Latency: REQ sampled at edge N, EV_VALID visible after edge N+2.
    do_req(16'h8005, 1'b0, 1'b0);
    chk("lat_n", EV_VALID, 0);
    tick();
    chk("lat_n1", EV_VALID, 0);
    tick();
    chk("lat_n2", EV_VALID, 1);
    chk("lat_addr", EV_ADDR, 0);
    chk("lat_ts", EV_TS, 0);
    chk("lat_last", EV_LAST, 0);
    drain("lat_drain");
    chk("lat_idle", EV_VALID, 0);

    // Table-driven single vectors.
    foreach (tbl[k]) begin
      base = obs_addr.size();
      do_req(tbl[k].vec, 1'b0, 1'b0);
      drain("tbl_drain");
      chk("tbl_count", obs_addr.size() - base, tbl[k].n_ev);
      if (obs_addr.size() > base) begin
        chk("tbl_lo", obs_addr[base], tbl[k].lo);
        chk("tbl_hi", obs_addr[obs_addr.size() - 1], tbl[k].hi);
      end
    end

    // Zero vector is discarded but still advances the timestep.
    do_reset();
    base = obs_addr.size();
    do_req(16'h0000, 1'b0, 1'b0);
    do_req(16'h0010, 1'b0, 1'b0);
    drain("zero_drain");
    chk("zero_count", obs_addr.size() - base, 1);
    if (obs_addr.size() > base) begin
      chk("zero_addr", obs_addr[base], 4);
      chk("zero_ts", obs_ts[base], 1);
    end

    // Back-pressure: first event held for 5 cycles, then 3 events in 3 cycles.
    do_reset();
    EV_READY = 1'b0;
    do_req(16'h8005, 1'b0, 1'b0);
    wait_valid("bp_valid");
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", EV_VALID, 1);
      chk("bp_hold_addr", EV_ADDR, 0);
      chk("bp_hold_ts", EV_TS, 0);
      tick();
    end
    base = obs_addr.size();
    EV_READY = 1'b1;
    tick();
    tick();
    tick();
    chk("bp_count", obs_addr.size() - base, 3);
    chk("bp_idle", EV_VALID, 0);
    drain("bp_drain");

    // Overflow: 6 vectors with sink stalled, capacity is 4 + 1.
    do_reset();
    EV_READY = 1'b0;
    do_req(16'h0001, 1'b0, 1'b0);
    do_req(16'h0001, 1'b0, 1'b0);
    do_req(16'h0001, 1'b0, 1'b0);
    chk("ovf_busy3", BUSY, 0);
    do_req(16'h0001, 1'b0, 1'b0);
    chk("ovf_busy4", BUSY, 1);
    do_req(16'h0001, 1'b0, 1'b0);
    chk("ovf_pre", OVF, 0);
    do_req(16'h0001, 1'b0, 1'b1);
    chk("ovf_set", OVF, 1);
    base = obs_addr.size();
    EV_READY = 1'b1;
    drain("ovf_drain");
    chk("ovf_count", obs_addr.size() - base, 5);
    chk("ovf_sticky", OVF, 1);
    chk("ovf_busy_clr", BUSY, 0);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    chk("ovf_clr", OVF, 0);

    // Timestep wrap, then TS_CLR coincident with REQ.
    do_reset();
    for (int n = 0; n < 257; n++) do_req(16'h0002, 1'b0, 1'b0);
    drain("wrap_drain");
    chk("wrap_last_ts", obs_ts[obs_ts.size() - 1], 0);
    do_req(16'h0002, 1'b1, 1'b0);
    do_req(16'h0002, 1'b0, 1'b0);
    drain("clr_drain");
    chk("clr_ts0", obs_ts[obs_ts.size() - 2], 0);
    chk("clr_ts1", obs_ts[obs_ts.size() - 1], 1);

    // Reset mid-stream drops everything pending.
    do_reset();
    EV_READY = 1'b0;
    for (int n = 0; n < 4; n++) do_req(16'h0007, 1'b0, 1'b0);
    chk("mid_valid_pre", EV_VALID, 1);
    chk("mid_busy_pre", BUSY, 1);
    base = obs_addr.size();
    do_reset();
    chk("mid_valid", EV_VALID, 0);
    chk("mid_busy", BUSY, 0);
    EV_READY = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    chk("mid_no_events", obs_addr.size() - base, 0);
    chk("mid_idle", EV_VALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_spike_aer_encoder.md
Name: cim_spike_aer_encoder

Overview:
Downstream consumer of the CIM macro's neuron outputs. It captures the 16-bit NEURON_OUT vector on each REQ pulse, tags it with a timestep number and buffers it in a small FIFO. Each set bit is then serialized into an address-event (AER) stream under a valid/ready handshake for the router/output interface. It decouples the macro's fixed 4-cycle compute pipeline from back-pressure in the event network.

Parameters:
NEURONS, 16, neurons per macro (width of NEURON_OUT)
FIFO_DEPTH, 4, buffered spike vectors (power of two, >=2)
TS_WIDTH, 8, timestep tag width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
REQ  in  1  one-cycle pulse from macro; NEURON_OUT valid this cycle
NEURON_OUT  in  NEURONS  fired-neuron vector
TS_CLR  in  1  clear timestep counter (new inference)
BUSY  out  1  FIFO count >= FIFO_DEPTH-1; upstream holds off EN
EV_VALID  out  1  event valid
EV_READY  in  1  event accepted when EV_VALID && EV_READY
EV_ADDR  out  log2(NEURONS)  neuron index of event
EV_TS  out  TS_WIDTH  timestep tag of event
EV_LAST  out  1  last event of current vector
OVF  out  1  sticky: a vector was dropped
OVF_CLR  in  1  clears OVF

Behaviour:
- One clock. Reset is synchronous and active-high: CLK, RST. RST on a rising edge clears FIFO, working register, timestep counter and OVF, and puts the FSM in IDLE. EV_VALID, EV_LAST, EV_ADDR, EV_TS, BUSY and OVF are all 0 after reset. Reset mid-stream drops all pending events with no partial output.
- Timestep counter ts increments by 1 on every sampled REQ, including zero and dropped vectors. It wraps from 2^TS_WIDTH-1 to 0.
- TS_CLR sets ts to 0. If TS_CLR and REQ coincide, the captured vector is tagged 0 and ts becomes 1.
- Push: on REQ with NEURON_OUT != 0, push {ts, NEURON_OUT}. A zero vector is not pushed.
- Push succeeds if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the vector is dropped and OVF is set.
- OVF_CLR clears OVF. If OVF_CLR coincides with a drop, the set wins.
- FSM IDLE:
  - If FIFO is non-empty, pop the head into the working register WORK/TS_R and go to SEND.
  - If FIFO is empty, stay in IDLE.
- FSM SEND:
  - EV_VALID=1.
  - EV_ADDR = index of the lowest set bit of WORK. EV_TS = TS_R.
  - EV_LAST=1 when WORK has exactly one set bit.
  - On handshake, clear that bit in WORK.
  - If EV_LAST was set: pop the next head directly if FIFO is non-empty (stay in SEND, no bubble); otherwise go to IDLE.
- Latency: REQ sampled at edge N gives EV_VALID=1 after edge N+2 when idle and empty. Steady throughput is 1 event per cycle with EV_READY=1.
- Handshake: EV_VALID, EV_ADDR, EV_TS and EV_LAST stay stable while EV_VALID && !EV_READY. EV_VALID never drops without acceptance, except on RST.
- Capacity: FIFO_DEPTH vectors in the FIFO plus 1 in WORK.
- BUSY is registered from the post-update count.

Optional Feature:
CIM_AER_NULL_EVENT_EN
- Defined: zero vectors are pushed. When such an entry reaches SEND, it emits one event with EV_ADDR=0, EV_LAST=1 and an extra output EV_NULL=1 (timestep marker). EV_NULL is 0 for all real events.
- Undefined: zero vectors are discarded. The EV_NULL port does not exist.

Decomposition:
- Package cim_aer_pkg:
  - NEURONS_DEFAULT and ADDR_WIDTH=$clog2(NEURONS)
  - FSM enum {IDLE, SEND}
  - packed struct aer_entry_t {ts, vec}
  - function lowest_set_index
  - function onehot_check (exactly-one-bit)
- Sub-module cim_aer_fifo: synchronous FIFO holding aer_entry_t, with push/pop/full/empty/count and simultaneous push+pop when full.

Test Plan:
- After reset, REQ with NEURON_OUT=16'h8005, EV_READY=1 -> EV_VALID rises after edge N+2. Events are addr 0,2,15 with EV_TS=0 and EV_LAST only on 15. EV_VALID=0 afterwards.
- Same vector with EV_READY low for 5 cycles after EV_VALID -> addr 0 and EV_TS held stable for 5 cycles, then 0,2,15 complete in 3 cycles.
- REQ with 16'h0000, then REQ with 16'h0010 -> exactly one event, addr 4, EV_TS=1.
- EV_READY=0, 6 REQs with 16'h0001 on consecutive cycles -> BUSY=1 by the 4th, 6th vector dropped, OVF=1. Release EV_READY -> 5 events with EV_TS 0..4. OVF_CLR -> OVF=0.
- 256 REQs of 16'h0002 then one more -> tags 0..255 then 0. TS_CLR coincident with REQ -> event tagged 0, next REQ tagged 1.
- RST asserted during SEND with 3 bits pending -> EV_VALID=0 after the edge, no further events, FIFO empty, BUSY=0.
